// File: rtl/memory_stream_pkg.sv
// Shared types and constants for the memory stream arbiter and its register slice.
package memory_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Byte-strobe width for a given data width
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register slice. The upstream side sees 'load' as its
// ready; a beat is taken whenever in_valid and load are both high. The same
// slice can sit on memory_wrapper's read side.
module axis_reg_slice #(
  parameter int WIDTH = 38
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             load,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Register is free when empty or being drained this cycle
  assign load = !out_valid || out_ready;

  // Capture a new beat, or drop valid once the held beat has been taken
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/memory_stream_arbiter.sv
// Packet-level round-robin arbiter: two AXI-Stream producers share one
// registered output stream into memory_wrapper. A grant lasts one packet.
// Optional macro ARB_STATS_EN adds per-requester packet counters.
module memory_stream_arbiter
  import memory_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       axis_aclk,
  input  logic                       axis_areset,
  input  logic [DATA_WIDTH-1:0]      s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s00_axis_tstrb,
  input  logic                       s00_axis_tvalid,
  input  logic                       s00_axis_tlast,
  output logic                       s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]      s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s01_axis_tstrb,
  input  logic                       s01_axis_tvalid,
  input  logic                       s01_axis_tlast,
  output logic                       s01_axis_tready,
  output logic [DATA_WIDTH-1:0]      m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m00_axis_tstrb,
  output logic                       m00_axis_tvalid,
  output logic                       m00_axis_tlast,
  output logic                       m00_axis_tid,
  input  logic                       m00_axis_tready
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]       pkt_cnt0,
  output logic [CNT_WIDTH-1:0]       pkt_cnt1
`endif
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int PW = DATA_WIDTH + SW + 2;   // {tid, tlast, tstrb, tdata}

  arb_state_t            state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  load;
  logic                  sel_valid, sel_last, sel_id, accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SW-1:0]         sel_strb;
  logic [PW-1:0]         out_payload;

  // Route the granted requester's beat toward the output register
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = s00_axis_tdata;
    sel_strb  = s00_axis_tstrb;
    sel_last  = s00_axis_tlast;
    sel_id    = 1'b0;
    case (state)
      GRANT0: sel_valid = s00_axis_tvalid;
      GRANT1: begin
        sel_valid = s01_axis_tvalid;
        sel_data  = s01_axis_tdata;
        sel_strb  = s01_axis_tstrb;
        sel_last  = s01_axis_tlast;
        sel_id    = 1'b1;
      end
      default: ;
    endcase
  end

  // Only the granted port sees ready; IDLE accepts nothing
  assign s00_axis_tready = (state == GRANT0) && load;
  assign s01_axis_tready = (state == GRANT1) && load;
  assign accept          = sel_valid && load;

  // Arbitration and packet-end detection
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid)
          state_nxt = last_grant ? GRANT0 : GRANT1;
        else if (s00_axis_tvalid)
          state_nxt = GRANT0;
        else if (s01_axis_tvalid)
          state_nxt = GRANT1;
      end
      GRANT0: begin
        if (accept && sel_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      GRANT1: begin
        if (accept && sel_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and round-robin history; last_grant=1 lets requester 0 win the first tie
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  axis_reg_slice #(.WIDTH(PW)) u_out_reg (
    .gclk      (axis_aclk),
    .grst      (axis_areset),
    .in_valid  (sel_valid),
    .in_data   ({sel_id, sel_last, sel_strb, sel_data}),
    .load      (load),
    .out_valid (m00_axis_tvalid),
    .out_data  (out_payload),
    .out_ready (m00_axis_tready)
  );

  assign {m00_axis_tid, m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = out_payload;

`ifdef ARB_STATS_EN
  // Count completed packets per requester, wrapping naturally
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (accept && sel_last) begin
      if (sel_id) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      else        pkt_cnt0 <= pkt_cnt0 + 1'b1;
    end
  end
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = |CNT_WIDTH;
`endif

endmodule

// File: tb/tb_memory_stream_arbiter.sv
// Self-checking bench for memory_stream_arbiter: scoreboard of accepted input
// beats against output beats, a table of arbitration vectors, and hand-written
// latency, backpressure, lock and mid-packet reset sequences.
module tb_memory_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
  logic [3:0]  s00_axis_tstrb, s01_axis_tstrb, m00_axis_tstrb;
  logic        s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic        s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic        m00_axis_tvalid, m00_axis_tlast, m00_axis_tid, m00_axis_tready;
`ifdef ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        tid;
    int          cyc;
  } beat_t;

  typedef struct {
    int         len0;
    int         len1;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         gap;
    bit         bp;
    bit         exp_first;
  } vec_t;

  beat_t sb[$];
  beat_t log_q[$];
  int    cyc = 0;
  int    ntests, nfail;
  int    h0, nlast0, nlast1, lock_viol;
  bit    s00_inflight, abort;

  memory_stream_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tid    (m00_axis_tid),
    .m00_axis_tready (m00_axis_tready)
`ifdef ARB_STATS_EN
    ,
    .pkt_cnt0        (pkt_cnt0),
    .pkt_cnt1        (pkt_cnt1)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put(input bit port, input bit v, input logic [7:0] d, input bit last);
    if (port) begin
      s01_axis_tvalid = v; s01_axis_tdata = {24'h0, d}; s01_axis_tstrb = d[3:0]; s01_axis_tlast = last;
    end else begin
      s00_axis_tvalid = v; s00_axis_tdata = {24'h0, d}; s00_axis_tstrb = d[3:0]; s00_axis_tlast = last;
    end
  endtask

  // Sends one packet; call right after a falling edge. Handshakes are judged
  // one time unit before the rising edge.
  task automatic drive(input bit port, input logic [7:0] base, input int len, input bit gap);
    int t;
    bit got;
    for (int i = 0; i < len; i++) begin
      if (abort) break;
      if (i > 0) @(negedge clk);
      if (gap && i == 1) begin
        put(port, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
      end
      put(port, 1'b1, base + 8'(i), (i == len - 1));
      got = 1'b0;
      t = 0;
      while (!got && !abort && t < 300) begin
        #4;
        if (!abort && (port ? s01_axis_tready : s00_axis_tready)) got = 1'b1;
        @(posedge clk);
        if (!got) @(negedge clk);
        t++;
      end
      if (!abort) chk("drive_handshake_in_budget", got, 1'b1);
    end
    if (!abort) @(negedge clk);
    put(port, 1'b0, 8'h00, 1'b0);
  endtask

  // Samples both sides just before every rising edge
  task automatic monitor();
    beat_t b, e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        chk("tready_onehot", s00_axis_tready & s01_axis_tready, 1'b0);
        if (m00_axis_tvalid && m00_axis_tready) begin
          b = '{data: m00_axis_tdata, strb: m00_axis_tstrb, last: m00_axis_tlast,
                tid: m00_axis_tid, cyc: cyc};
          log_q.push_back(b);
          chk("sb_nonempty_on_output", (sb.size() != 0), 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_tdata", b.data, e.data);
            chk("out_tstrb", b.strb, e.strb);
            chk("out_tlast", b.last, e.last);
            chk("out_tid",   b.tid,  e.tid);
          end
        end
        if (s00_inflight && s01_axis_tready) lock_viol++;
        if (s00_axis_tvalid && s00_axis_tready) begin
          sb.push_back('{data: s00_axis_tdata, strb: s00_axis_tstrb, last: s00_axis_tlast,
                         tid: 1'b0, cyc: cyc});
          h0++;
          if (s00_axis_tlast) begin nlast0++; s00_inflight = 1'b0; end
          else s00_inflight = 1'b1;
        end
        if (s01_axis_tvalid && s01_axis_tready) begin
          sb.push_back('{data: s01_axis_tdata, strb: s01_axis_tstrb, last: s01_axis_tlast,
                         tid: 1'b1, cyc: cyc});
          if (s01_axis_tlast) nlast1++;
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m00_axis_tvalid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_budget", (t < 200), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    nlast0 = 0; nlast1 = 0; s00_inflight = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[6];

  initial begin
    int t, st, sw, bnd, hb;
    bit done;
    tbl[0] = '{2, 2, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0};  // tie out of reset -> s00
    tbl[1] = '{3, 3, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};  // next tie -> s00 again
    tbl[2] = '{0, 3, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1};  // s01 alone
    tbl[3] = '{1, 0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0};  // single-beat s00
    tbl[4] = '{2, 2, 8'h80, 8'h90, 1'b1, 1'b0, 1'b1};  // tie after s00 -> s01, mid-packet gap
    tbl[5] = '{3, 3, 8'hB0, 8'hC0, 1'b0, 1'b1, 1'b1};  // tie under random backpressure

    ntests = 0; nfail = 0; h0 = 0; nlast0 = 0; nlast1 = 0; lock_viol = 0;
    s00_inflight = 1'b0; abort = 1'b0;
    put(1'b0, 1'b0, 8'h00, 1'b0);
    put(1'b1, 1'b0, 8'h00, 1'b0);
    m00_axis_tready = 1'b1;
    rst = 1'b1;
    fork monitor(); join_none
    repeat (3) @(negedge clk);

    chk("rst_m_tvalid", m00_axis_tvalid, 1'b0);
    chk("rst_m_tdata",  m00_axis_tdata, 32'h0);
    chk("rst_m_tstrb",  m00_axis_tstrb, 4'h0);
    chk("rst_m_tlast",  m00_axis_tlast, 1'b0);
    chk("rst_m_tid",    m00_axis_tid, 1'b0);
    chk("rst_s00_tready", s00_axis_tready, 1'b0);
    chk("rst_s01_tready", s01_axis_tready, 1'b0);
`ifdef ARB_STATS_EN
    chk("rst_pkt_cnt0", pkt_cnt0, 16'h0);
    chk("rst_pkt_cnt1", pkt_cnt1, 16'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single requester: 2-cycle first-beat latency, then 1 beat/cycle
    log_q.delete();
    st = cyc;
    drive(1'b0, 8'h68, 4, 1'b0);
    drain();
    chk("A_beats", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("A_data", log_q[i].data, 32'h68 + i);
        chk("A_cycle", log_q[i].cyc, st + 2 + i);
        chk("A_tid", log_q[i].tid, 1'b0);
        chk("A_tlast", log_q[i].last, (i == 3));
      end

    // Arbitration vectors from a fresh reset
    do_reset();
    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v = tbl[r];
      log_q.delete();
      done = 1'b0;
      fork
        begin
          fork
            drive(1'b0, v.b0, v.len0, v.gap);
            drive(1'b1, v.b1, v.len1, v.gap);
          join
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            if (v.bp) m00_axis_tready = 1'($urandom_range(0, 1));
          end
          m00_axis_tready = 1'b1;
        end
      join
      drain();
      chk("T_beats", log_q.size(), v.len0 + v.len1);
      if (log_q.size() > 0) chk("T_first_tid", log_q[0].tid, v.exp_first);
      sw = 0; bnd = 0;
      for (int i = 1; i < log_q.size(); i++)
        if (log_q[i].tid != log_q[i-1].tid) begin sw++; bnd = i; end
      chk("T_no_interleave", sw, (v.len0 > 0 && v.len1 > 0) ? 1 : 0);
      if (v.len0 > 0 && v.len1 > 0 && !v.bp && bnd > 0)
        chk("T_idle_gap", log_q[bnd].cyc - log_q[bnd-1].cyc, 2);
    end
`ifdef ARB_STATS_EN
    chk("T_pkt_cnt0", pkt_cnt0, nlast0);
    chk("T_pkt_cnt1", pkt_cnt1, nlast1);
`endif

    // Backpressure: stall 5 cycles mid-packet, output frozen, no loss
    log_q.delete();
    fork
      drive(1'b0, 8'hA0, 6, 1'b0);
      begin
        beat_t snap;
        t = 0;
        while (log_q.size() < 2 && t < 100) begin @(negedge clk); t++; end
        chk("B_reached_stall_point", (log_q.size() >= 2), 1'b1);
        m00_axis_tready = 1'b0;
        #4;
        snap = '{data: m00_axis_tdata, strb: m00_axis_tstrb, last: m00_axis_tlast,
                 tid: m00_axis_tid, cyc: 0};
        chk("B_held_valid", m00_axis_tvalid, 1'b1);
        chk("B_s00_tready", s00_axis_tready, 1'b0);
        chk("B_s01_tready", s01_axis_tready, 1'b0);
        repeat (4) begin
          @(negedge clk);
          #4;
          chk("B_stable_valid", m00_axis_tvalid, 1'b1);
          chk("B_stable_data", m00_axis_tdata, snap.data);
          chk("B_stable_strb", m00_axis_tstrb, snap.strb);
          chk("B_stable_last", m00_axis_tlast, snap.last);
          chk("B_stable_tid", m00_axis_tid, snap.tid);
          chk("B_s00_tready", s00_axis_tready, 1'b0);
          chk("B_s01_tready", s01_axis_tready, 1'b0);
        end
        @(negedge clk);
        m00_axis_tready = 1'b1;
      end
    join
    drain();
    chk("B_beats", log_q.size(), 6);
    if (log_q.size() == 6)
      for (int i = 0; i < 6; i++) chk("B_order", log_q[i].data, 32'hA0 + i);

    // Lock: s01 arrives during an s00 packet and must wait for its tlast
    log_q.delete();
    lock_viol = 0;
    fork
      drive(1'b0, 8'hC0, 4, 1'b0);
      begin
        repeat (2) @(negedge clk);
        drive(1'b1, 8'hE0, 2, 1'b0);
      end
    join
    drain();
    chk("C_lock_violations", lock_viol, 0);
    chk("C_beats", log_q.size(), 6);
    if (log_q.size() == 6)
      for (int i = 0; i < 6; i++) chk("C_packet_order", log_q[i].tid, (i >= 4));

    // Reset mid-packet: output clears asynchronously, next packet is clean
    log_q.delete();
    hb = h0;
    fork
      drive(1'b0, 8'hF0, 4, 1'b0);
      begin
        t = 0;
        while (h0 < hb + 2 && t < 100) begin @(negedge clk); t++; end
        chk("D_reached_beat2", (h0 >= hb + 2), 1'b1);
        #2;
        rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("D_async_tvalid", m00_axis_tvalid, 1'b0);
        chk("D_async_tdata", m00_axis_tdata, 32'h0);
        chk("D_async_s00_tready", s00_axis_tready, 1'b0);
        sb.delete();
        s00_inflight = 1'b0;
        nlast0 = 0; nlast1 = 0;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    @(negedge clk);
`ifdef ARB_STATS_EN
    chk("D_pkt_cnt0_cleared", pkt_cnt0, 16'h0);
`endif
    log_q.delete();
    st = cyc;
    drive(1'b0, 8'h30, 2, 1'b0);
    drain();
    chk("D_after_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("D_after_first_cycle", log_q[0].cyc, st + 2);
      chk("D_after_data0", log_q[0].data, 32'h30);
      chk("D_after_data1", log_q[1].data, 32'h31);
    end
`ifdef ARB_STATS_EN
    chk("D_pkt_cnt0", pkt_cnt0, 16'h1);
    chk("D_pkt_cnt1", pkt_cnt1, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
